hilo_divider: RTL and testbench

- Sequential HI/LO register block for the MIPS datapath.
- Consumes the ALU's combinational {hi,lo} multiply result and mthi/mtlo writes.
- Performs multi-cycle DIV/DIVU: remainder goes to HI, quotient goes to LO.
- Feeds mfhi/mflo reads and drives a busy signal so the pipeline stalls HI/LO consumers.

---
 rtl/hilo_divider.sv | 188 ++++++++++++++++++
 tb/tb_hilo_divider.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : hilo_divider
//  Purpose  : MIPS HI/LO register block. Accepts multiply results and
//             mthi/mtlo writes, runs a WIDTH-cycle restoring DIV/DIVU
//             (remainder -> HI, quotient -> LO) and flags busy so the
//             pipeline can stall HI/LO consumers.
//  Options  : HILO_DIV0_FLAG_EN - when defined, a zero divisor finishes in
//             one cycle with div_by_zero pulsed and HI/LO left unchanged;
//             when undefined, div_by_zero is 0 and the divide runs normally.
//  Revision : 1.0 - initial release
// ============================================================================
module hilo_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             sign,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             mul_we,
    input  logic [WIDTH-1:0] mul_hi,
    input  logic [WIDTH-1:0] mul_lo,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero
);

    localparam int                 c_cnt_w = $clog2(WIDTH);
    localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2,
        S_ZERO = 2'd3
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic [WIDTH-1:0]   r_rem;
    logic [WIDTH-1:0]   r_quo;
    logic [WIDTH-1:0]   r_div;
    logic [c_cnt_w-1:0] r_cnt;
    logic               r_qneg;
    logic               r_rneg;
    logic               r_done;

    logic               w_wr;
    logic [WIDTH-1:0]   w_amag;
    logic [WIDTH-1:0]   w_bmag;
    logic [WIDTH:0]     w_rs;
    logic [WIDTH:0]     w_trial;
    logic               w_borrow;
    logic [WIDTH-1:0]   w_quo_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // Any architectural write wins over divide control and aborts a divide.
    assign w_wr = mul_we | mthi | mtlo;

    // Operand magnitudes for signed divide; DIVU uses the raw values.
    assign w_amag = (sign && a[WIDTH-1]) ? (~a + 1'b1) : a;
    assign w_bmag = (sign && b[WIDTH-1]) ? (~b + 1'b1) : b;

    // One restoring step: shift the next dividend bit into the remainder and
    // try subtracting the divisor with one extra bit to expose the borrow.
    assign w_rs     = {r_rem, r_quo[WIDTH-1]};
    assign w_trial  = w_rs - {1'b0, r_div};
    assign w_borrow = w_trial[WIDTH];

    // Sign correction applied once at the end of a signed divide.
    assign w_quo_fix = r_qneg ? (~r_quo + 1'b1) : r_quo;
    assign w_rem_fix = r_rneg ? (~r_rem + 1'b1) : r_rem;

    assign hi   = r_hi;
    assign lo   = r_lo;
    assign busy = (r_state != S_IDLE);
    assign done = r_done;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    // Next-state logic; a write strobe returns to IDLE from any state.
    always_comb begin
        w_next = r_state;
        if (w_wr) begin
            w_next = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
`ifdef HILO_DIV0_FLAG_EN
                        w_next = (b == '0) ? S_ZERO : S_RUN;
`else
                        w_next = S_RUN;
`endif
                    end
                end
                S_RUN:   if (r_cnt == c_last) w_next = S_FIX;
                S_FIX:   w_next = S_IDLE;
                S_ZERO:  w_next = S_IDLE;
                default: w_next = S_IDLE;
            endcase
        end
    end

    // HI/LO registers, divider datapath and completion pulse.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi   <= '0;
            r_lo   <= '0;
            r_rem  <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
            r_qneg <= 1'b0;
            r_rneg <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_wr) begin
                if (mul_we) begin
                    r_hi <= mul_hi;
                    r_lo <= mul_lo;
                end else begin
                    if (mthi) r_hi <= wdata;
                    if (mtlo) r_lo <= wdata;
                end
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (start) begin
                            r_rem  <= '0;
                            r_quo  <= w_amag;
                            r_div  <= w_bmag;
                            r_cnt  <= '0;
                            r_qneg <= sign & (a[WIDTH-1] ^ b[WIDTH-1]);
                            r_rneg <= sign & a[WIDTH-1];
                        end
                    end
                    S_RUN: begin
                        r_rem <= w_borrow ? w_rs[WIDTH-1:0] : w_trial[WIDTH-1:0];
                        r_quo <= {r_quo[WIDTH-2:0], ~w_borrow};
                        r_cnt <= r_cnt + 1'b1;
                    end
                    S_FIX: begin
                        r_hi   <= w_rem_fix;
                        r_lo   <= w_quo_fix;
                        r_done <= 1'b1;
                    end
                    S_ZERO: begin
                        r_done <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

`ifdef HILO_DIV0_FLAG_EN
    logic r_dbz;

    // Zero-divisor flag accompanies the early done from ZERO.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)                          r_dbz <= 1'b0;
        else if (!w_wr && r_state == S_ZERO) r_dbz <= 1'b1;
        else                                r_dbz <= 1'b0;
    end

    assign div_by_zero = r_dbz;
`else
    assign div_by_zero = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_hilo_divider.sv
`default_nettype none
// ============================================================================
//  Module   : tb_hilo_divider
//  Purpose  : Directed self-checking bench for hilo_divider.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_hilo_divider;

    logic        clk;
    logic        reset;
    logic        start;
    logic        sign;
    logic [31:0] a;
    logic [31:0] b;
    logic        mul_we;
    logic [31:0] mul_hi;
    logic [31:0] mul_lo;
    logic        mthi;
    logic        mtlo;
    logic [31:0] wdata;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        done;
    logic        div_by_zero;

    int checks   = 0;
    int failures = 0;

    hilo_divider #(.WIDTH(32)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .sign        (sign),
        .a           (a),
        .b           (b),
        .mul_we      (mul_we),
        .mul_hi      (mul_hi),
        .mul_lo      (mul_lo),
        .mthi        (mthi),
        .mtlo        (mtlo),
        .wdata       (wdata),
        .hi          (hi),
        .lo          (lo),
        .busy        (busy),
        .done        (done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Present a divide request and step past its start edge (E0).
    task automatic start_div(input logic s, input logic [31:0] da, input logic [31:0] db);
        sign  = s;
        a     = da;
        b     = db;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Start a divide and return the number of edges after E0 until done shows.
    task automatic run_div(input logic s, input logic [31:0] da, input logic [31:0] db,
                           output int lat, output logic busy_at_start);
        start_div(s, da, db);
        busy_at_start = busy;
        lat = -1;
        for (int n = 1; n <= 40; n++) begin
            @(posedge clk);
            #1;
            if (done) begin
                lat = n;
                break;
            end
        end
    endtask

    // Watch a window of cycles and report whether done ever pulsed.
    task automatic watch_done(input int cycles, output logic seen);
        seen = 1'b0;
        for (int n = 0; n < cycles; n++) begin
            @(posedge clk);
            #1;
            if (done) seen = 1'b1;
        end
    endtask

    initial begin
        int   lat;
        logic bs;
        logic seen;

        reset  = 1'b1;
        start  = 1'b0;
        sign   = 1'b0;
        a      = '0;
        b      = '0;
        mul_we = 1'b0;
        mul_hi = '0;
        mul_lo = '0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        wdata  = '0;

        #2;
        check("reset_hi",   hi, 32'h0);
        check("reset_lo",   lo, 32'h0);
        check("reset_busy", {31'b0, busy}, 32'h0);
        check("reset_done", {31'b0, done}, 32'h0);
        check("reset_dbz",  {31'b0, div_by_zero}, 32'h0);
        #20;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // DIVU 100 / 7
        run_div(1'b0, 32'd100, 32'd7, lat, bs);
        check("divu100_busy_start", {31'b0, bs}, 32'h1);
        check("divu100_latency", 32'(lat), 32'd33);
        check("divu100_lo", lo, 32'd14);
        check("divu100_hi", hi, 32'd2);
        check("divu100_busy_at_done", {31'b0, busy}, 32'h0);
        @(posedge clk);
        #1;
        check("divu100_done_one_cycle", {31'b0, done}, 32'h0);
        check("divu100_hi_hold", hi, 32'd2);

        // DIV -7 / 2
        run_div(1'b1, 32'hFFFF_FFF9, 32'd2, lat, bs);
        check("div_neg7_latency", 32'(lat), 32'd33);
        check("div_neg7_lo", lo, 32'hFFFF_FFFD);
        check("div_neg7_hi", hi, 32'hFFFF_FFFF);

        // DIV most-negative / -1 wraps
        run_div(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, lat, bs);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        // DIVU 5 / 9
        run_div(1'b0, 32'd5, 32'd9, lat, bs);
        check("divu5_9_lo", lo, 32'd0);
        check("divu5_9_hi", hi, 32'd5);

        // DIVU 123 / 0
        run_div(1'b0, 32'd123, 32'd0, lat, bs);
`ifdef HILO_DIV0_FLAG_EN
        check("div0_latency", 32'(lat), 32'd1);
        check("div0_flag", {31'b0, div_by_zero}, 32'h1);
        check("div0_lo_unchanged", lo, 32'd0);
        check("div0_hi_unchanged", hi, 32'd5);
`else
        check("div0_latency", 32'(lat), 32'd33);
        check("div0_flag", {31'b0, div_by_zero}, 32'h0);
        check("div0_lo", lo, 32'hFFFF_FFFF);
        check("div0_hi", hi, 32'd123);
`endif
        @(posedge clk);
        #1;
        check("div0_done_one_cycle", {31'b0, done}, 32'h0);
        check("div0_flag_clear", {31'b0, div_by_zero}, 32'h0);

        // mul_we at iteration 10 aborts the divide
        start_div(1'b0, 32'd100, 32'd7);
        repeat (10) @(posedge clk);
        #1;
        check("abort_busy_before", {31'b0, busy}, 32'h1);
        mul_we = 1'b1;
        mul_hi = 32'hAAAA_0000;
        mul_lo = 32'h0000_5555;
        @(posedge clk);
        #1;
        mul_we = 1'b0;
        check("abort_hi", hi, 32'hAAAA_0000);
        check("abort_lo", lo, 32'h0000_5555);
        check("abort_busy", {31'b0, busy}, 32'h0);
        watch_done(40, seen);
        check("abort_no_done", {31'b0, seen}, 32'h0);
        check("abort_hi_hold", hi, 32'hAAAA_0000);

        // A fresh start after the abort is accepted
        run_div(1'b0, 32'd100, 32'd7, lat, bs);
        check("restart_latency", 32'(lat), 32'd33);
        check("restart_lo", lo, 32'd14);
        check("restart_hi", hi, 32'd2);

        // Asynchronous reset at iteration 5
        start_div(1'b1, 32'd100, 32'd7);
        repeat (5) @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        check("midreset_hi", hi, 32'h0);
        check("midreset_lo", lo, 32'h0);
        check("midreset_busy", {31'b0, busy}, 32'h0);
        #2;
        reset = 1'b0;
        watch_done(40, seen);
        check("midreset_no_done", {31'b0, seen}, 32'h0);

        // mthi and mtlo together
        mthi  = 1'b1;
        mtlo  = 1'b1;
        wdata = 32'h0000_1234;
        @(posedge clk);
        #1;
        mthi = 1'b0;
        mtlo = 1'b0;
        check("mthilo_hi", hi, 32'h0000_1234);
        check("mthilo_lo", lo, 32'h0000_1234);

        // start together with mthi in IDLE: the write happens, start ignored
        sign  = 1'b0;
        a     = 32'd100;
        b     = 32'd7;
        start = 1'b1;
        mthi  = 1'b1;
        wdata = 32'h0000_0055;
        @(posedge clk);
        #1;
        start = 1'b0;
        mthi  = 1'b0;
        check("start_wr_hi", hi, 32'h0000_0055);
        check("start_wr_lo", lo, 32'h0000_1234);
        check("start_wr_busy", {31'b0, busy}, 32'h0);

        // mul_we outranks mthi/mtlo
        mul_we = 1'b1;
        mthi   = 1'b1;
        mtlo   = 1'b1;
        mul_hi = 32'h1111_2222;
        mul_lo = 32'h3333_4444;
        wdata  = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        mul_we = 1'b0;
        mthi   = 1'b0;
        mtlo   = 1'b0;
        check("prio_hi", hi, 32'h1111_2222);
        check("prio_lo", lo, 32'h3333_4444);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Hard stop in case the sequence above ever stalls.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
